// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - mode encoding and signed range helpers for accumulating_adder
package adder_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_ADD        = 2'd0;
  localparam mode_t MODE_SUB        = 2'd1;
  localparam mode_t MODE_ACCUMULATE = 2'd2;
  localparam mode_t MODE_LOAD       = 2'd3;

  function automatic logic signed [63:0] max_pos(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] max_neg(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/widened_adder.sv
// rtl/widened_adder.sv - sign-extended add/sub with overflow; ADDER_SATURATE_EN clamps instead of wrapping
module widened_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  logic [WIDTH:0] wide_a;
  logic [WIDTH:0] wide_b;
  logic [WIDTH:0] wide_sum;

  assign wide_a = {a[WIDTH-1], a};
  assign wide_b = {b[WIDTH-1], b};

  // WIDTH+1 bits hold every true sum/difference, including x - most_negative
  assign wide_sum = subtract ? (wide_a - wide_b) : (wide_a + wide_b);
  assign overflow = wide_sum[WIDTH] ^ wide_sum[WIDTH-1];

`ifdef ADDER_SATURATE_EN
  localparam logic signed [63:0] MAX_POS_W = adder_pkg::max_pos(WIDTH);
  localparam logic signed [63:0] MAX_NEG_W = adder_pkg::max_neg(WIDTH);
  localparam logic [WIDTH-1:0]   MAX_POS   = MAX_POS_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0]   MAX_NEG   = MAX_NEG_W[WIDTH-1:0];

  always_comb begin
    sum = wide_sum[WIDTH-1:0];
    if (overflow) begin
      sum = wide_sum[WIDTH] ? MAX_NEG : MAX_POS;
    end
  end
`else
  assign sum = wide_sum[WIDTH-1:0];
`endif

endmodule

// File: rtl/accumulating_adder.sv
// rtl/accumulating_adder.sv - registered add/sub/accumulate/load with handshakes; ADDER_SATURATE_EN selects clamping
module accumulating_adder
  import adder_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inputValid,
  output logic                   inputReady,
  input  logic [WIDTH-1:0]       operand0,
  input  logic [WIDTH-1:0]       operand1,
  input  logic [1:0]             mode,
  output logic                   outputValid,
  input  logic                   outputReady,
  output logic [WIDTH-1:0]       result,
  output logic                   overflow,
  output logic                   stickyOverflow,
  output logic [COUNT_WIDTH-1:0] count
);

  logic                   valid_q, valid_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   ovf_q, ovf_d;
  logic                   sticky_q, sticky_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0]       acc_q, acc_d;

  logic             accept;
  mode_t            op_mode;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_sub, add_ovf;

  assign op_mode    = mode_t'(mode);
  assign inputReady = !valid_q || outputReady;
  assign accept     = inputValid && inputReady;

  // LOAD passes operand0 through the adder with a zero addend, so it can never overflow
  always_comb begin
    add_a   = operand0;
    add_b   = operand1;
    add_sub = 1'b0;
    case (op_mode)
      MODE_SUB:        add_sub = 1'b1;
      MODE_ACCUMULATE: begin
        add_a = acc_q;
        add_b = operand0;
      end
      MODE_LOAD:       add_b = '0;
      default:         ;
    endcase
  end

  widened_adder #(.WIDTH(WIDTH)) u_adder (
    .a        (add_a),
    .b        (add_b),
    .subtract (add_sub),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    count_d  = count_q;
    acc_d    = acc_q;
    if (accept) begin
      valid_d  = 1'b1;
      result_d = add_sum;
      ovf_d    = add_ovf;
      sticky_d = sticky_q | add_ovf;
      case (op_mode)
        MODE_ACCUMULATE: begin
          acc_d = add_sum;
          if (count_q != '1) begin
            count_d = count_q + 1'b1;
          end
        end
        MODE_LOAD: begin
          acc_d    = operand0;
          count_d  = '0;
          sticky_d = 1'b0;
        end
        default: ;
      endcase
    end else if (outputReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
      acc_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
    end
  end

  assign outputValid    = valid_q;
  assign result         = result_q;
  assign overflow       = ovf_q;
  assign stickyOverflow = sticky_q;
  assign count          = count_q;

endmodule
